// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared types for the write-back stage: mem_size encodings,
//               the pending-entry record and the load formatter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    // Widest supported datapath and register address. Entries are stored at
    // these widths and narrowed by the instantiating module.
    localparam int c_MAX_XLEN = 64;
    localparam int c_MAX_AW   = 8;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } wb_size_e;

    typedef struct packed {
        logic                  valid;
        logic [c_MAX_AW-1:0]   rd;
        logic [c_MAX_XLEN-1:0] data;
    } wb_pend_t;

    // Shift the raw word down to the accessed lane, truncate to the access
    // size and extend. A double on a 32-bit datapath behaves as a word, and
    // the full-width access passes through untouched.
    function automatic logic [c_MAX_XLEN-1:0] fmt_load(
        input logic [c_MAX_XLEN-1:0] raw,
        input logic [1:0]            size,
        input logic                  uns,
        input logic [2:0]            off,
        input logic                  is64
    );
        logic [c_MAX_XLEN-1:0] s;
        logic [c_MAX_XLEN-1:0] r;
        s = raw >> {off, 3'b000};
        r = s;
        case (size)
            SZ_B:    r = uns ? {56'd0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
            SZ_H:    r = uns ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
            SZ_W:    r = !is64 ? s :
                         (uns ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]});
            default: r = s;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_pend_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_pend_fifo
// Description : Circular buffer of pending MEM results with head pop and a
//               parallel rd compare that invalidates squashed entries.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_pend_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         push,
    input  wire logic [AW-1:0]                push_rd,
    input  wire logic [DW-1:0]                push_data,
    input  wire logic                         pop,
    input  wire logic                         squash,
    input  wire logic [AW-1:0]                squash_rd,
    output logic                              head_valid,
    output logic [AW-1:0]                     head_rd,
    output logic [DW-1:0]                     head_data,
    output logic [$clog2(DEPTH+1)-1:0]        count
);

    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_pend_t          r_mem [DEPTH];
    logic [c_PW-1:0]   r_rd_ptr;
    logic [c_PW-1:0]   r_wr_ptr;
    logic [c_CW-1:0]   r_count;
    logic [DEPTH-1:0]  w_hit;
    wb_pend_t          w_head;
    wb_pend_t          w_push_ent;
    logic              w_unused_head;

    // Wrap explicitly so non-power-of-two depths work.
    function automatic logic [c_PW-1:0] ptr_next(input logic [c_PW-1:0] p);
        if (p == c_PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // One comparator per entry so a squash clears all matches at once.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_squash
        assign w_hit[gi] = squash && (r_mem[gi].rd == c_MAX_AW'(squash_rd));
    end

    assign w_head        = r_mem[r_rd_ptr];
    assign head_valid    = w_head.valid;
    assign head_rd       = w_head.rd[AW-1:0];
    assign head_data     = w_head.data[DW-1:0];
    assign count         = r_count;
    assign w_unused_head = ^{w_head.rd, w_head.data};

    assign w_push_ent = '{valid: 1'b1,
                          rd:    c_MAX_AW'(push_rd),
                          data:  c_MAX_XLEN'(push_data)};

    // Storage, pointers and occupancy; the pushed slot is always free, so a
    // squash never collides with the entry written in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_hit[i]) begin
                    r_mem[i].valid <= 1'b0;
                end
            end
            if (push) begin
                r_mem[r_wr_ptr] <= w_push_ent;
                r_wr_ptr        <= ptr_next(r_wr_ptr);
            end
            if (pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            if (push && !pop) begin
                r_count <= r_count + 1'b1;
            end else if (pop && !push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_pipe
// Description : Registered write-back stage. Formats loads, arbitrates EXE
//               results, pending loads and direct loads onto the single
//               register-file write port.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage_pipe
    import wb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5,
    parameter int PEND_DEPTH = 2
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       exe_we,
    input  wire logic [REG_AW-1:0]          exe_rd,
    input  wire logic [XLEN-1:0]            exe_data,
    input  wire logic                       mem_valid,
    input  wire logic [REG_AW-1:0]          mem_rd,
    input  wire logic [XLEN-1:0]            mem_rdata,
    input  wire logic [1:0]                 mem_size,
    input  wire logic                       mem_unsigned,
    input  wire logic [$clog2(XLEN/8)-1:0]  mem_byte_off,
    output logic                            mem_ready,
    output logic                            rf_we,
    output logic [REG_AW-1:0]               rf_rd_addr,
    output logic [XLEN-1:0]                 rf_rd_data,
    output logic                            wb_done
);

    localparam int c_CW = $clog2(PEND_DEPTH + 1);

    logic                   w_accept;
    logic                   w_drop;
    logic [c_MAX_XLEN-1:0]  w_fmt_full;
    logic [XLEN-1:0]        w_fmt;
    logic                   w_unused_fmt;
    logic                   w_head_valid;
    logic [REG_AW-1:0]      w_head_rd;
    logic [XLEN-1:0]        w_head_data;
    logic [c_CW-1:0]        w_count;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_issue;
    logic [REG_AW-1:0]      w_iss_rd;
    logic [XLEN-1:0]        w_iss_data;

    assign w_fmt_full   = fmt_load(c_MAX_XLEN'(mem_rdata), mem_size, mem_unsigned,
                                   3'(mem_byte_off), (XLEN == 64));
    assign w_fmt        = w_fmt_full[XLEN-1:0];
    assign w_unused_fmt = ^w_fmt_full;

    // Ready looks only at the registered count, never at a same-cycle pop.
    assign mem_ready = !rst && (w_count < c_CW'(PEND_DEPTH));
    assign w_accept  = mem_valid && mem_ready;
    // A same-cycle load to the EXE destination is older and simply lost.
    assign w_drop    = exe_we && w_accept && (exe_rd == mem_rd);

    // Port arbitration: EXE first, then the buffer head, then a direct load.
    always_comb begin
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_issue    = 1'b0;
        w_iss_rd   = '0;
        w_iss_data = '0;
        if (exe_we) begin
            w_issue    = 1'b1;
            w_iss_rd   = exe_rd;
            w_iss_data = exe_data;
            w_push     = w_accept && !w_drop;
        end else if (w_count != '0) begin
            w_pop      = 1'b1;
            w_issue    = w_head_valid;
            w_iss_rd   = w_head_rd;
            w_iss_data = w_head_data;
            w_push     = w_accept;
        end else if (w_accept) begin
            w_issue    = 1'b1;
            w_iss_rd   = mem_rd;
            w_iss_data = w_fmt;
        end
    end

    wb_pend_fifo #(
        .DEPTH (PEND_DEPTH),
        .AW    (REG_AW),
        .DW    (XLEN)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .push_rd    (mem_rd),
        .push_data  (w_fmt),
        .pop        (w_pop),
        .squash     (exe_we),
        .squash_rd  (exe_rd),
        .head_valid (w_head_valid),
        .head_rd    (w_head_rd),
        .head_data  (w_head_data),
        .count      (w_count)
    );

    // Register the retiring result; r0 retires without a write enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_rd_addr <= '0;
            rf_rd_data <= '0;
            wb_done    <= 1'b0;
        end else begin
            rf_we   <= w_issue && (w_iss_rd != '0);
            wb_done <= w_issue;
            if (w_issue) begin
                rf_rd_addr <= w_iss_rd;
                rf_rd_data <= w_iss_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage_pipe
// Description : Self-checking bench for wb_stage_pipe (XLEN=32, depth 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage_pipe;

    localparam int XLEN       = 32;
    localparam int REG_AW     = 5;
    localparam int PEND_DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              exe_we;
    logic [4:0]        exe_rd;
    logic [31:0]       exe_data;
    logic              mem_valid;
    logic [4:0]        mem_rd;
    logic [31:0]       mem_rdata;
    logic [1:0]        mem_size;
    logic              mem_unsigned;
    logic [1:0]        mem_byte_off;
    logic              mem_ready;
    logic              rf_we;
    logic [4:0]        rf_rd_addr;
    logic [31:0]       rf_rd_data;
    logic              wb_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_stage_pipe #(
        .XLEN       (XLEN),
        .REG_AW     (REG_AW),
        .PEND_DEPTH (PEND_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .exe_we       (exe_we),
        .exe_rd       (exe_rd),
        .exe_data     (exe_data),
        .mem_valid    (mem_valid),
        .mem_rd       (mem_rd),
        .mem_rdata    (mem_rdata),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .mem_byte_off (mem_byte_off),
        .mem_ready    (mem_ready),
        .rf_we        (rf_we),
        .rf_rd_addr   (rf_rd_addr),
        .rf_rd_data   (rf_rd_data),
        .wb_done      (wb_done)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        exe_we = 0; exe_rd = 0; exe_data = 0;
        mem_valid = 0; mem_rd = 0; mem_rdata = 0;
        mem_size = 0; mem_unsigned = 0; mem_byte_off = 0;
    endtask

    task automatic set_exe(input logic [4:0] rd, input logic [31:0] d);
        exe_we = 1; exe_rd = rd; exe_data = d;
    endtask

    task automatic set_mem(input logic [4:0] rd, input logic [31:0] d, input logic [1:0] sz,
                           input logic un, input logic [1:0] off);
        mem_valid = 1; mem_rd = rd; mem_rdata = d;
        mem_size = sz; mem_unsigned = un; mem_byte_off = off;
    endtask

    // Checks write-enable and done; address/data only when a write is expected.
    task automatic chk_out(input string nm, input logic we, input logic done,
                           input logic [4:0] a, input logic [31:0] d);
        chk({nm, ".we"}, rf_we, we);
        chk({nm, ".done"}, wb_done, done);
        if (we) begin
            chk({nm, ".addr"}, rf_rd_addr, a);
            chk({nm, ".data"}, rf_rd_data, d);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          v;
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    bit          e_we, e_done, zr;
    logic [4:0]  e_addr;
    logic [31:0] e_data;

    function automatic logic [31:0] ref_fmt(logic [31:0] raw, int sz, bit uns, int off);
        logic [63:0] v, mask;
        int nb;
        nb   = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        v    = {32'd0, raw} >> (8 * off);
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v    = v & mask;
        if (!uns && (((v >> (8 * nb - 1)) & 64'd1) != 0)) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic model_cycle();
        bit acc, iv;
        ent_t e;
        logic [4:0] ird;
        logic [31:0] idat;
        #1;
        chk("rand.mem_ready", mem_ready, (!rst && q.size() < PEND_DEPTH));
        iv = 0; ird = 0; idat = 0;
        if (rst) begin
            q.delete();
            e_we = 0; e_done = 0; e_addr = 0; e_data = 0; zr = 1;
        end else begin
            acc = mem_valid && (q.size() < PEND_DEPTH);
            if (exe_we) begin
                iv = 1; ird = exe_rd; idat = exe_data;
                foreach (q[i]) if (q[i].rd == exe_rd) q[i].v = 0;
                if (acc && mem_rd != exe_rd)
                    q.push_back('{1'b1, mem_rd, ref_fmt(mem_rdata, mem_size, mem_unsigned, mem_byte_off)});
            end else if (q.size() > 0) begin
                e = q.pop_front();
                iv = e.v; ird = e.rd; idat = e.d;
                if (acc)
                    q.push_back('{1'b1, mem_rd, ref_fmt(mem_rdata, mem_size, mem_unsigned, mem_byte_off)});
            end else if (acc) begin
                iv = 1; ird = mem_rd;
                idat = ref_fmt(mem_rdata, mem_size, mem_unsigned, mem_byte_off);
            end
            e_we = iv && (ird != 0);
            e_done = iv;
            if (iv) begin
                e_addr = ird; e_data = idat; zr = 0;
            end
        end
        tick();
        chk("rand.we", rf_we, e_we);
        chk("rand.done", wb_done, e_done);
        if (e_we || zr) begin
            chk("rand.addr", rf_rd_addr, e_addr);
            chk("rand.data", rf_rd_data, e_data);
        end
    endtask

    // ---------------- single-cycle vector table ----------------
    typedef struct {
        logic        ew;
        logic [4:0]  erd;
        logic [31:0] ed;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic [1:0]  sz;
        logic        un;
        logic [1:0]  off;
        logic        xwe;
        logic [4:0]  xa;
        logic [31:0] xd;
        logic        xdone;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1, 10, 32'h12345678, 0, 0,  32'h0,        0, 0, 0, 1, 10, 32'h12345678, 1};
        tbl[1]  = '{0, 0,  32'h0,        1, 12, 32'hCAFEBABE, 0, 0, 3, 1, 12, 32'hFFFFFFCA, 1};
        tbl[2]  = '{0, 0,  32'h0,        1, 12, 32'hCAFEBABE, 1, 1, 0, 1, 12, 32'h0000BABE, 1};
        tbl[3]  = '{0, 0,  32'h0,        1, 13, 32'hCAFEBABE, 2, 0, 0, 1, 13, 32'hCAFEBABE, 1};
        tbl[4]  = '{0, 0,  32'h0,        1, 14, 32'hCAFEBABE, 0, 1, 1, 1, 14, 32'h000000BA, 1};
        tbl[5]  = '{0, 0,  32'h0,        1, 15, 32'hCAFEBABE, 1, 0, 2, 1, 15, 32'hFFFFCAFE, 1};
        tbl[6]  = '{0, 0,  32'h0,        1, 16, 32'hCAFEBABE, 3, 0, 0, 1, 16, 32'hCAFEBABE, 1};
        tbl[7]  = '{0, 0,  32'h0,        1, 5,  32'h0000007F, 0, 0, 0, 1, 5,  32'h0000007F, 1};
        tbl[8]  = '{0, 0,  32'h0,        1, 0,  32'h11111111, 2, 0, 0, 0, 0,  32'h0,        1};
        tbl[9]  = '{1, 0,  32'h55,       0, 0,  32'h0,        0, 0, 0, 0, 0,  32'h0,        1};
        tbl[10] = '{0, 0,  32'h0,        1, 17, 32'h80010000, 1, 1, 2, 1, 17, 32'h00008001, 1};

        idle_inputs();
        rst = 1;
        #1;
        chk("reset.mem_ready", mem_ready, 0);
        tick();
        tick();
        chk("reset.we", rf_we, 0);
        chk("reset.addr", rf_rd_addr, 0);
        chk("reset.data", rf_rd_data, 0);
        chk("reset.done", wb_done, 0);
        rst = 0;
        tick();
        chk("post_reset.we", rf_we, 0);
        chk("post_reset.mem_ready", mem_ready, 1);

        // Table: one transaction, one drain cycle.
        for (int i = 0; i < 11; i++) begin
            idle_inputs();
            if (tbl[i].ew) set_exe(tbl[i].erd, tbl[i].ed);
            if (tbl[i].mv) set_mem(tbl[i].mrd, tbl[i].mdat, tbl[i].sz, tbl[i].un, tbl[i].off);
            tick();
            chk_out($sformatf("vec%0d", i), tbl[i].xwe, tbl[i].xdone, tbl[i].xa, tbl[i].xd);
            idle_inputs();
            tick();
            chk_out($sformatf("vec%0d.drain", i), 0, 0, 0, 0);
        end

        // Collision: EXE wins, the load follows one cycle later.
        set_exe(3, 32'h1);
        set_mem(4, 32'hAA, 2, 0, 0);
        tick();
        chk_out("coll.c1", 1, 1, 3, 32'h1);
        idle_inputs();
        tick();
        chk_out("coll.c2", 1, 1, 4, 32'hAA);
        tick();
        chk_out("coll.c3", 0, 0, 0, 0);
        chk("coll.ready", mem_ready, 1);

        // Squash: queued r7 is invalidated by a later EXE write to r7.
        set_exe(1, 32'h5);
        set_mem(7, 32'h77, 2, 0, 0);
        tick();
        chk_out("sq.c1", 1, 1, 1, 32'h5);
        idle_inputs();
        set_exe(7, 32'h9);
        tick();
        chk_out("sq.c2", 1, 1, 7, 32'h9);
        idle_inputs();
        tick();
        chk_out("sq.pop_invalid", 0, 0, 0, 0);
        tick();
        chk_out("sq.idle", 0, 0, 0, 0);

        // Same-cycle drop.
        set_exe(7, 32'h9);
        set_mem(7, 32'h55, 2, 0, 0);
        tick();
        chk_out("drop.c1", 1, 1, 7, 32'h9);
        idle_inputs();
        tick();
        chk_out("drop.c2", 0, 0, 0, 0);
        tick();
        chk_out("drop.c3", 0, 0, 0, 0);

        // Full buffer: 4 EXE writes, MEM offers held until accepted.
        begin
            int mi;
            logic [4:0]  xa [8];
            logic        xr [8];
            xa = '{20, 21, 22, 23, 24, 25, 26, 0};
            xr = '{1, 1, 0, 0, 0, 1, 1, 1};
            mi = 0;
            for (int c = 0; c < 8; c++) begin
                idle_inputs();
                if (c < 4) set_exe(5'(20 + c), 32'(c + 32'h200));
                if (mi < 3) set_mem(5'(24 + mi), 32'(32'h100 + mi), 2, 0, 0);
                #1;
                chk($sformatf("full.ready%0d", c), mem_ready, xr[c]);
                if (mem_valid && mem_ready) mi++;
                tick();
                if (c < 4)
                    chk_out($sformatf("full.out%0d", c), 1, 1, xa[c], 32'(c + 32'h200));
                else if (c < 7)
                    chk_out($sformatf("full.out%0d", c), 1, 1, xa[c], 32'(32'h100 + c - 4));
                else
                    chk_out($sformatf("full.out%0d", c), 0, 0, 0, 0);
            end
        end

        // Reset with two entries pending, then a load to r0.
        idle_inputs();
        set_exe(1, 32'h3);
        set_mem(2, 32'h22, 2, 0, 0);
        tick();
        set_mem(3, 32'h33, 2, 0, 0);
        tick();
        idle_inputs();
        rst = 1;
        #1;
        chk("rst2.ready", mem_ready, 0);
        tick();
        rst = 0;
        chk("rst2.we", rf_we, 0);
        chk("rst2.addr", rf_rd_addr, 0);
        chk("rst2.data", rf_rd_data, 0);
        chk("rst2.done", wb_done, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("rst2.idle%0d.we", c), rf_we, 0);
            chk($sformatf("rst2.idle%0d.done", c), wb_done, 0);
            chk($sformatf("rst2.idle%0d.data", c), rf_rd_data, 0);
        end
        set_mem(0, 32'h44, 2, 0, 0);
        tick();
        chk_out("r0.load", 0, 1, 0, 0);
        idle_inputs();
        tick();

        // Randomized traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            rst          = (i == 0) || ($urandom_range(0, 63) == 0);
            exe_we       = ($urandom_range(0, 1) == 1);
            exe_rd       = 5'($urandom_range(0, 7));
            exe_data     = $urandom;
            mem_valid    = ($urandom_range(0, 9) < 6);
            mem_rd       = 5'($urandom_range(0, 7));
            mem_rdata    = $urandom;
            mem_size     = 2'($urandom_range(0, 3));
            mem_unsigned = 1'($urandom_range(0, 1));
            mem_byte_off = 2'($urandom_range(0, 3));
            model_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_stage_pipe.md
# wb_stage_pipe

Registered, parametrised write-back stage: accepts ALU results from EXE and load data from MEM in the same cycle, formats loads (byte/half/word/double, signed/unsigned), and serialises both onto the register file's single write port. A small pending buffer absorbs MEM results that lose the port. Sits between the MEM stage and the register file, replacing the combinational write-back unit.

## Interface
- `XLEN`, 32: datapath width; legal values 32 or 64.
- `REG_AW`, 5: register-file address width.
- `PEND_DEPTH`, 2: pending MEM-result entries; must be ≥1.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `exe_we` in 1: EXE result valid and requests a write.
- `exe_rd` in REG_AW: EXE destination register.
- `exe_data` in XLEN: EXE result.
- `mem_valid` in 1: load result valid; consumed only when `mem_valid & mem_ready`.
- `mem_rd` in REG_AW: load destination.
- `mem_rdata` in XLEN: raw aligned memory word.
- `mem_size` in 2: 0 byte, 1 half, 2 word, 3 double (double legal only when XLEN=64).
- `mem_unsigned` in 1: 1 zero-extends, 0 sign-extends.
- `mem_byte_off` in $clog2(XLEN/8): byte lane of the access.
- `mem_ready` out 1: pending buffer can accept.
- `rf_we` out 1: register-file write enable.
- `rf_rd_addr` out REG_AW: write address.
- `rf_rd_data` out XLEN: write data.
- `wb_done` out 1: one-cycle pulse per retired result, including writes to register 0.

## Operation
- Load formatting happens on accept: data is shifted right by `8*mem_byte_off`, truncated to the size, then extended per `mem_unsigned`. Word on XLEN=32 and double on XLEN=64 pass through unchanged. Word on XLEN=64 is extended. Formatted data is what gets stored or written.
- Port arbitration each cycle, in priority order:
  1. `exe_we=1`: the EXE result takes the port. An accepted MEM result is enqueued.
  2. Otherwise, if the buffer is non-empty: pop the head. An accepted MEM result is enqueued in the same cycle.
  3. Otherwise, if a MEM result is accepted: write it directly.
- Same cycle, `exe_we & mem_valid & mem_ready` with `exe_rd == mem_rd`: the MEM result is dropped, not enqueued. EXE is younger.
- Squash: an EXE write invalidates every valid pending entry whose rd equals `exe_rd`. Popping an invalid entry uses the cycle with `rf_we=0` and `wb_done=0`.
- Register 0: the result retires with `rf_we=0` and `wb_done=1`. It is still enqueued and arbitrated normally.
- `mem_ready = !rst & (count < PEND_DEPTH)`. It depends only on registered count and is independent of the same-cycle pop.
- Accepting with `count == PEND_DEPTH` is impossible by construction. The bench asserts `mem_valid & !mem_ready` never changes state.
- Illegal `mem_size=3` on XLEN=32 is treated as word.

## Timing
- Latency is 1 cycle from input (or pop) to `rf_*`/`wb_done`. All outputs are registered.
- During and after reset: `rf_we=0`, `rf_rd_addr=0`, `rf_rd_data=0`, `wb_done=0`, buffer empty, count=0, `mem_ready=0` while `rst=1`.
- Reset mid-operation discards all pending entries. No write issues in the cycle after reset deasserts.
- When the buffer is full and EXE writes every cycle, `mem_ready` stays 0 until the first cycle with `exe_we=0`. That cycle pops, and ready rises in the following cycle.
- Buffer pointers wrap modulo PEND_DEPTH. A non-power-of-two depth must work.
- A pop and an enqueue in the same cycle keep count unchanged, including when full.

## Structure
- Shared package `wb_pkg`: `mem_size` encodings (`SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`) and the pending-entry struct (valid, rd, data).
- Sub-module `wb_pend_fifo`:
  - Circular buffer with count and head pop.
  - Per-entry parallel rd compare and invalidate for squash.
- Load formatter is a function in `wb_pkg`.

## Test plan
- **EXE only.** `exe_we=1`, rd=10, data=32'h12345678 → next cycle `rf_we=1`, addr=10, data=32'h12345678, `wb_done=1`.
- **Load formatting.** rdata=32'hCAFEBABE, rd=12, no EXE:
  - byte, off=3, signed → data=32'hFFFFFFCA.
  - half, off=0, unsigned → 32'h0000BABE.
- **Collision.** EXE rd=3, data=1 and MEM rd=4, word 32'hAA in the same cycle → cycle+1 writes r3=1, cycle+2 writes r4=32'hAA, count returns to 0.
- **Squash and drop.**
  - MEM rd=7 queued behind EXE, then EXE rd=7 data=9 → r7=9 written, the queued entry pops with `rf_we=0`, no second write to r7.
  - Same-cycle EXE/MEM both rd=7 → only the EXE write occurs.
- **Full buffer.** PEND_DEPTH=2, EXE writes 4 consecutive cycles while MEM offers every cycle → `mem_ready` drops after 2 accepts, no loss or duplication, MEM writes drain in order.
- **Reset and register 0.** Reset with 2 entries pending → none written afterwards, outputs 0. Then MEM rd=0 → `rf_we=0`, `wb_done=1`.
